// File: rtl/alu_issue.sv
// alu_issue -- MIPS ALU-stage issue register.
//
// Decodes one MIPS instruction word per accepted handshake into an ALU
// operation select plus operands, and holds the result in an output
// register behind a valid/ready handshake (latency 1).
//
// Build option: define ALU_ISSUE_SKID_EN to add a one-entry skid buffer.
// This makes in_ready a registered (~skid_full) signal, so an instruction
// offered while the output stalls is still taken once. Without the macro,
// in_ready is derived combinationally from the output handshake.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake (instr, rs_data, rt_data)
//   flush               drop every held entry at the next clk
//   out_valid/out_ready ALU-side handshake
//   ALUCode, A, B       ALU operation select and operands
//   ovf_en              overflow traps for this op (add, sub, addi)
//   illegal             unrecognised encoding (payload zeroed)
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  ALUCode,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        ovf_en,
  output logic        illegal
);

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf;
    logic        ill;
  } payload_t;

  payload_t dec;
  payload_t out_reg;
  logic     out_valid_reg;
  logic     accept;

  // The rs register number is consumed upstream as rs_data.
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];

  // ---------------- combinational decode ----------------
  always_comb begin
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    op    = instr[31:26];
    funct = instr[5:0];
    rt    = instr[20:16];
    imm_s = {{16{instr[15]}}, instr[15:0]};
    imm_z = {16'b0, instr[15:0]};
    dec      = '0;
    dec.a    = rs_data;
    dec.b    = rt_data;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin dec.code = 5'b00000; dec.ovf = 1'b1; end
          6'h21: dec.code = 5'b00000;
          6'h22: begin dec.code = 5'b00101; dec.ovf = 1'b1; end
          6'h23: dec.code = 5'b00101;
          6'h24: dec.code = 5'b00001;
          6'h25: dec.code = 5'b00011;
          6'h26: dec.code = 5'b00010;
          6'h27: dec.code = 5'b00100;
          6'h2A: dec.code = 5'b10011;
          6'h2B: dec.code = 5'b10100;
          6'h08: dec.code = 5'b01001;
          // Immediate shifts: shift amount comes from the shamt field.
          6'h00: begin dec.code = 5'b10000; dec.a = {27'b0, instr[10:6]}; end
          6'h02: begin dec.code = 5'b10001; dec.a = {27'b0, instr[10:6]}; end
          6'h03: begin dec.code = 5'b10010; dec.a = {27'b0, instr[10:6]}; end
          // Variable shifts: shift amount is the low five bits of rs.
          6'h04: begin dec.code = 5'b10000; dec.a = {27'b0, rs_data[4:0]}; end
          6'h06: begin dec.code = 5'b10001; dec.a = {27'b0, rs_data[4:0]}; end
          6'h07: begin dec.code = 5'b10010; dec.a = {27'b0, rs_data[4:0]}; end
          default: dec.ill = 1'b1;
        endcase
      end
      6'h08: begin dec.code = 5'b00000; dec.b = imm_s; dec.ovf = 1'b1; end
      6'h09, 6'h23, 6'h2B: begin dec.code = 5'b00000; dec.b = imm_s; end
      6'h0A: begin dec.code = 5'b10011; dec.b = imm_s; end
      6'h0B: begin dec.code = 5'b10100; dec.b = imm_s; end
      6'h0C: begin dec.code = 5'b00110; dec.b = imm_z; end
      6'h0D: begin dec.code = 5'b01000; dec.b = imm_z; end
      6'h0E: begin dec.code = 5'b00111; dec.b = imm_z; end
      6'h04: dec.code = 5'b01010;
      6'h05: dec.code = 5'b01011;
      6'h06: dec.code = 5'b01110;
      6'h07: dec.code = 5'b01101;
      6'h01: begin
        dec.b = '0;
        if (rt == 5'd0)      dec.code = 5'b01111;
        else if (rt == 5'd1) dec.code = 5'b01100;
        else                 dec.ill  = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal encodings still travel through the pipe, with a clean payload.
    if (dec.ill) begin
      dec      = '0;
      dec.ill  = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

`ifdef ALU_ISSUE_SKID_EN
  payload_t skid_reg;
  logic     skid_full_reg;
  logic     in_ready_reg;
  logic     out_free;

  // in_ready_reg mirrors ~skid_full_reg; reset and flush only gate it.
  assign in_ready = in_ready_reg & ~reset & ~flush;
  assign out_free = ~out_valid_reg | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      skid_reg      <= '0;
      skid_full_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      skid_full_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else if (out_free) begin
      if (skid_full_reg) begin
        // Older parked entry goes first; in_ready was low so nothing new.
        out_reg       <= skid_reg;
        out_valid_reg <= 1'b1;
        skid_full_reg <= 1'b0;
        in_ready_reg  <= 1'b1;
      end else if (accept) begin
        out_reg       <= dec;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_reg      <= dec;
      skid_full_reg <= 1'b1;
      in_ready_reg  <= 1'b0;
    end
  end
`else
  assign in_ready = ~reset & ~flush & (out_ready | ~out_valid_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_reg       <= dec;
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_reg;
  assign ALUCode   = out_reg.code;
  assign A         = out_reg.a;
  assign B         = out_reg.b;
  assign ovf_en    = out_reg.ovf;
  assign illegal   = out_reg.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue: decode vectors, stalled stream,
// flush and mid-stall reset. Works with or without ALU_ISSUE_SKID_EN.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  ALUCode;
  logic [31:0] A;
  logic [31:0] B;
  logic        ovf_en;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ALUCode(ALUCode),
    .A(A), .B(B), .ovf_en(ovf_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] code, input logic [31:0] a,
                           input logic [31:0] b, input logic ovf, input logic ill);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".ALUCode"}, {27'b0, ALUCode}, {27'b0, code});
    check({tag, ".A"}, A, a);
    check({tag, ".B"}, B, b);
    check({tag, ".ovf_en"}, {31'b0, ovf_en}, {31'b0, ovf});
    check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ill});
  endtask

  // Offer one instruction, wait (bounded) for in_ready, complete the handshake.
  task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    int w;
    w = 0;
    instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1;
    #1;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    if (w >= 20) check("issue_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".ALUCode"}, {27'b0, ALUCode}, 32'd0);
    check({tag, ".A"}, A, 32'd0);
    check({tag, ".B"}, B, 32'd0);
    check({tag, ".ovf_en"}, {31'b0, ovf_en}, 32'd0);
    check({tag, ".illegal"}, {31'b0, illegal}, 32'd0);
  endtask

  logic [31:0] s_instr [4];
  logic [31:0] s_rs    [4];
  logic [31:0] s_rt    [4];
  logic [4:0]  s_code  [4];
  logic [31:0] s_a     [4];
  logic [31:0] s_b     [4];
  logic        s_ovf   [4];

  initial begin
    int acc;
    int emi;
    logic fire_in;
    logic fire_out;

    // Stream: sub, or, ori, beq with hand-computed results.
    s_instr[0] = 32'h00221822; s_rs[0] = 32'd10;    s_rt[0] = 32'd3;
    s_code[0]  = 5'b00101;     s_a[0]  = 32'd10;    s_b[0]  = 32'd3;      s_ovf[0] = 1'b1;
    s_instr[1] = 32'h00221825; s_rs[1] = 32'hF0;    s_rt[1] = 32'h0F;
    s_code[1]  = 5'b00011;     s_a[1]  = 32'hF0;    s_b[1]  = 32'h0F;     s_ovf[1] = 1'b0;
    s_instr[2] = 32'h3422FFFF; s_rs[2] = 32'h100;   s_rt[2] = 32'h999;
    s_code[2]  = 5'b01000;     s_a[2]  = 32'h100;   s_b[2]  = 32'h0000FFFF; s_ovf[2] = 1'b0;
    s_instr[3] = 32'h10220004; s_rs[3] = 32'd5;     s_rt[3] = 32'd6;
    s_code[3]  = 5'b01010;     s_a[3]  = 32'd5;     s_b[3]  = 32'd6;      s_ovf[3] = 1'b0;

    reset = 1'b1; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("reset.in_ready", {31'b0, in_ready}, 32'd0);
    check_zero("reset");
    reset = 1'b0;
    step();

    // ---------------- decode vectors ----------------
    issue(32'h00221820, 32'h7FFFFFFF, 32'h1);
    check_out("add", 5'b00000, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0);
    issue(32'h00021903, 32'h12345678, 32'h80000000);
    check_out("sra", 5'b10010, 32'h4, 32'h80000000, 1'b0, 1'b0);
    issue(32'h30228001, 32'hFFFF0000, 32'h5);
    check_out("andi", 5'b00110, 32'hFFFF0000, 32'h00008001, 1'b0, 1'b0);
    issue(32'h04210010, 32'hFFFFFFFF, 32'h77);
    check_out("bgez", 5'b01100, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    issue(32'hFC000000, 32'h55, 32'h66);
    check_out("op3F", 5'b00000, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(32'h2022FFFC, 32'h10, 32'h20);
    check_out("addi", 5'b00000, 32'h10, 32'hFFFFFFFC, 1'b1, 1'b0);
    issue(32'h00221804, 32'h123, 32'hABCD);
    check_out("sllv", 5'b10000, 32'h3, 32'hABCD, 1'b0, 1'b0);
    issue(32'h00221821, 32'h7FFFFFFF, 32'h1);
    check_out("addu", 5'b00000, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    issue(32'h0022182A, 32'h8, 32'h9);
    check_out("slt", 5'b10011, 32'h8, 32'h9, 1'b0, 1'b0);
    issue(32'h04200010, 32'h80000000, 32'h3);
    check_out("bltz", 5'b01111, 32'h80000000, 32'h0, 1'b0, 1'b0);
    issue(32'h00221801, 32'h1, 32'h2);
    check_out("rtype_bad", 5'b00000, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(32'h04220000, 32'h1, 32'h2);
    check_out("regimm_bad", 5'b00000, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    check("idle.out_valid", {31'b0, out_valid}, 32'd0);

    // ---------------- stream with 3-cycle stall ----------------
    acc = 0;
    emi = 0;
    for (int c = 0; c < 30 && emi < 4; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (acc < 4);
      if (acc < 4) begin
        instr = s_instr[acc]; rs_data = s_rs[acc]; rt_data = s_rt[acc];
      end
      #1;
`ifdef ALU_ISSUE_SKID_EN
      if (c == 2) check("skid.in_ready_c2", {31'b0, in_ready}, 32'd1);
      if (c == 3) check("skid.in_ready_c3", {31'b0, in_ready}, 32'd0);
`endif
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      // Every cycle with valid output (stalled or not) must show the next
      // in-order entry, which also proves the payload holds during stall.
      if (out_valid) check_out($sformatf("stream%0d", emi), s_code[emi], s_a[emi],
                               s_b[emi], s_ovf[emi], 1'b0);
      if (fire_out) emi++;
      if (fire_in) acc++;
      step();
    end
    in_valid = 1'b0;
    check("stream.emitted", emi, 32'd4);
    check("stream.accepted", acc, 32'd4);
    step();

    // ---------------- flush with stalled output (and skid if present) ----------------
    out_ready = 1'b0;
    issue(32'h00221820, 32'h1, 32'h2);
    check("flush.pre_valid", {31'b0, out_valid}, 32'd1);
    instr = 32'h00221822; rs_data = 32'h3; rt_data = 32'h4; in_valid = 1'b1;
    step();
    instr = 32'h00221824; flush = 1'b1;
    #1;
    check("flush.in_ready", {31'b0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("flush.stale%0d", k), {31'b0, out_valid}, 32'd0);
    end

    // ---------------- reset during stall ----------------
    out_ready = 1'b0;
    issue(32'h0022182B, 32'h9, 32'hA);
    check("rst.pre_valid", {31'b0, out_valid}, 32'd1);
    instr = 32'h00221826; in_valid = 1'b1;
    step();
    reset = 1'b1; flush = 1'b1;
    #1;
    check("rst.in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check_zero("rst");
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("rst.no_stale", {31'b0, out_valid}, 32'd0);
    issue(32'h00221820, 32'h7FFFFFFF, 32'h1);
    check_out("post_rst_add", 5'b00000, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
